// File: rtl/dmem_lane_arbiter.sv
// Arbitrates the two pipeline memory lanes onto the dual-port dmem, preserving program order.
// Optional macro DMEM_ARB_FWD_EN: forward lane a store data to a same-address lane b load.
module dmem_lane_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [ADDR_W-1:0] address_dmem_a,
  output logic [ADDR_W-1:0] address_dmem_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_a,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_dmem_a,
  input  logic [DATA_W-1:0] q_dmem_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic              stall,
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic same, merge, fwd, serial;
  logic issue_a, issue_b, stall_c, fwd_hit;

  always_comb begin
    same  = req_a & req_b & (addr_a == addr_b);
    merge = same & we_a & we_b;
`ifdef DMEM_ARB_FWD_EN
    fwd   = same & we_a & ~we_b;
`else
    fwd   = 1'b0;
`endif
    serial = same & (we_a ^ we_b) & ~fwd;
  end

  // Lane issue decisions; SECOND always finishes the held lane b op regardless of inputs.
  always_comb begin
    state_d = state_q;
    issue_a = 1'b0;
    issue_b = 1'b0;
    stall_c = 1'b0;
    fwd_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (merge) begin
          issue_b = 1'b1;
        end else if (serial) begin
          issue_a = 1'b1;
          stall_c = 1'b1;
          state_d = SECOND;
        end else if (fwd) begin
          issue_a = 1'b1;
          fwd_hit = 1'b1;
        end else begin
          issue_a = req_a;
          issue_b = req_b;
        end
      end
      SECOND: begin
        issue_b = req_b;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rvalid_a_d = issue_a & ~we_a;
    rvalid_b_d = (issue_b & ~we_b) | fwd_hit;
    rdata_a_d  = rvalid_a_d ? q_dmem_a : rdata_a_q;
    if (fwd_hit)
      rdata_b_d = wdata_a;
    else if (rvalid_b_d)
      rdata_b_d = q_dmem_b;
    else
      rdata_b_d = rdata_b_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == SECOND && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      cnt_q      <= cnt_d;
    end
  end

  // Un-issued lanes still present their address/data; only wren distinguishes them.
  assign address_dmem_a = addr_a;
  assign address_dmem_b = addr_b;
  assign data_a         = wdata_a;
  assign data_b         = wdata_b;
  assign wren_a         = issue_a & we_a & ~reset;
  assign wren_b         = issue_b & we_b & ~reset;
  assign stall          = stall_c & ~reset;
  assign rdata_a        = rdata_a_q;
  assign rdata_b        = rdata_b_q;
  assign rvalid_a       = rvalid_a_q;
  assign rvalid_b       = rvalid_b_q;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Scoreboard bench for dmem_lane_arbiter: program-order memory model vs DUT with a behavioural dmem.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_dmem_lane_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
`ifdef DMEM_ARB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
  logic [ADDR_W-1:0] address_dmem_a, address_dmem_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              wren_a, wren_b;
  logic [DATA_W-1:0] q_dmem_a = '0, q_dmem_b = '0;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              rvalid_a, rvalid_b, stall;
  logic [CNT_W-1:0]  conflict_count;

  logic [ADDR_W-1:0] sm_address_dmem_a, sm_address_dmem_b;
  logic [DATA_W-1:0] sm_data_a, sm_data_b, sm_rdata_a, sm_rdata_b;
  logic              sm_wren_a, sm_wren_b, sm_rvalid_a, sm_rvalid_b, sm_stall;
  logic [1:0]        sm_conflict_count;

  int errors = 0;
  int checks = 0;
  int cnt_exp = 0;
  int cnt_small = 0;

  logic [DATA_W-1:0] dmem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  bit dmem_init_done = 1'b0;

  always #5 clock = ~clock;

  dmem_lane_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .address_dmem_a(address_dmem_a), .address_dmem_b(address_dmem_b),
    .data_a(data_a), .data_b(data_b), .wren_a(wren_a), .wren_b(wren_b),
    .q_dmem_a(q_dmem_a), .q_dmem_b(q_dmem_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .stall(stall), .conflict_count(conflict_count)
  );

  dmem_lane_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) dut_small (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .address_dmem_a(sm_address_dmem_a), .address_dmem_b(sm_address_dmem_b),
    .data_a(sm_data_a), .data_b(sm_data_b), .wren_a(sm_wren_a), .wren_b(sm_wren_b),
    .q_dmem_a(q_dmem_a), .q_dmem_b(q_dmem_b),
    .rdata_a(sm_rdata_a), .rdata_b(sm_rdata_b), .rvalid_a(sm_rvalid_a), .rvalid_b(sm_rvalid_b),
    .stall(sm_stall), .conflict_count(sm_conflict_count)
  );

  function automatic logic [DATA_W-1:0] initWord(input int i);
    if (i == 'h010) return 32'hDEADBEEF;
    if (i == 'h030) return 32'h7;
    return i * 32'h9E3779B1;
  endfunction

  // Behavioural dmem clocked on ~clock: read-old-data, then apply writes.
  always @(negedge clock) begin
    if (!dmem_init_done) begin
      for (int i = 0; i < (1 << ADDR_W); i++) dmem[i] = initWord(i);
      dmem_init_done = 1'b1;
    end
    q_dmem_a <= dmem[address_dmem_a];
    q_dmem_b <= dmem[address_dmem_b];
    if (wren_a) dmem[address_dmem_a] = data_a;
    if (wren_b) dmem[address_dmem_b] = data_b;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected load data on each rvalid, otherwise rdata must hold.
  logic [DATA_W-1:0] last_a = '0, last_b = '0;
  bit prev_reset = 1'b1;
  always @(negedge clock) begin
    if (prev_reset) begin
      last_a = '0;
      last_b = '0;
    end
    if (rvalid_a) begin
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL rvalid_a_unexpected: got rdata_a=0x%0h expected no rvalid", rdata_a);
      end else begin
        last_a = exp_a_q.pop_front();
        checkOutput("rdata_a", rdata_a, last_a);
      end
    end else begin
      checkOutput("rdata_a_hold", rdata_a, last_a);
    end
    if (rvalid_b) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL rvalid_b_unexpected: got rdata_b=0x%0h expected no rvalid", rdata_b);
      end else begin
        last_b = exp_b_q.pop_front();
        checkOutput("rdata_b", rdata_b, last_b);
      end
    end else begin
      checkOutput("rdata_b_hold", rdata_b, last_b);
    end
    prev_reset = reset;
  end

  // Issues one lane pair at posedge+1; the model applies a then b in program order.
  task automatic applyStimulus(input logic ra, input logic wa, input logic [ADDR_W-1:0] aa,
                               input logic [DATA_W-1:0] da, input logic rb, input logic wb,
                               input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
    bit same, merge, fwd, serial;
    logic exp_wa, exp_wb;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    same   = ra && rb && (aa == ab);
    merge  = same && wa && wb;
    fwd    = FWD_EN && same && wa && !wb;
    serial = same && (wa != wb) && !fwd;
    if (ra) begin
      if (wa) ref_mem[aa] = da;
      else exp_a_q.push_back(ref_mem[aa]);
    end
    if (rb) begin
      if (wb) ref_mem[ab] = db;
      else exp_b_q.push_back(ref_mem[ab]);
    end
    if (merge) begin exp_wa = 1'b0; exp_wb = 1'b1; end
    else if (serial || fwd) begin exp_wa = wa; exp_wb = 1'b0; end
    else begin exp_wa = ra && wa; exp_wb = rb && wb; end
    #2;
    checkOutput("stall_c1", {31'b0, stall}, {31'b0, serial});
    checkOutput("wren_a_c1", {31'b0, wren_a}, {31'b0, exp_wa});
    checkOutput("wren_b_c1", {31'b0, wren_b}, {31'b0, exp_wb});
    checkOutput("address_dmem_b", {20'b0, address_dmem_b}, {20'b0, ab});
    checkOutput("data_b", data_b, db);
    checkOutput("conflict_count_c1", {16'b0, conflict_count}, cnt_exp);
    checkOutput("conflict_small_c1", {30'b0, sm_conflict_count}, cnt_small);
    @(posedge clock); #1;
    if (serial) begin
      if (cnt_exp < 16'hFFFF) cnt_exp++;
      if (cnt_small < 3) cnt_small++;
      #2;
      checkOutput("stall_c2", {31'b0, stall}, 32'd0);
      checkOutput("wren_a_c2", {31'b0, wren_a}, 32'd0);
      checkOutput("wren_b_c2", {31'b0, wren_b}, {31'b0, wb});
      checkOutput("conflict_count_c2", {16'b0, conflict_count}, cnt_exp);
      checkOutput("conflict_small_c2", {30'b0, sm_conflict_count}, cnt_small);
      @(posedge clock); #1;
    end
  endtask

  // Lane a load + lane b store to one address, with reset landing in the second cycle.
  task automatic resetInSecond(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_a = 1; we_a = 0; addr_a = a; wdata_a = '0;
    req_b = 1; we_b = 1; addr_b = a; wdata_b = d;
    exp_a_q.push_back(ref_mem[a]);
    #2;
    checkOutput("rst_stall_c1", {31'b0, stall}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    #2;
    checkOutput("rst_wren_b", {31'b0, wren_b}, 32'd0);
    checkOutput("rst_wren_a", {31'b0, wren_a}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    req_a = 0; req_b = 0;
    cnt_exp = 0;
    cnt_small = 0;
    #2;
    checkOutput("rst_conflict_count", {16'b0, conflict_count}, 32'd0);
    checkOutput("rst_rvalid_b", {31'b0, rvalid_b}, 32'd0);
    checkOutput("rst_stall_after", {31'b0, stall}, 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = initWord(i);
    req_a = 1; we_a = 1; addr_a = 12'h001; wdata_a = 32'h11;
    req_b = 1; we_b = 1; addr_b = 12'h002; wdata_b = 32'h22;
    repeat (2) @(posedge clock);
    #3;
    checkOutput("reset_wren_a", {31'b0, wren_a}, 32'd0);
    checkOutput("reset_wren_b", {31'b0, wren_b}, 32'd0);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_rvalid_a", {31'b0, rvalid_a}, 32'd0);
    checkOutput("reset_rvalid_b", {31'b0, rvalid_b}, 32'd0);
    checkOutput("reset_rdata_a", rdata_a, 32'd0);
    checkOutput("reset_rdata_b", rdata_b, 32'd0);
    checkOutput("reset_conflict_count", {16'b0, conflict_count}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    req_a = 0; req_b = 0;
    @(posedge clock); #1;

    $display("[TB] directed cases");
    applyStimulus(1, 0, 12'h010, 32'h0, 1, 1, 12'h011, 32'h5);
    applyStimulus(1, 1, 12'h020, 32'h1, 1, 1, 12'h020, 32'h2);
    applyStimulus(1, 0, 12'h020, 32'h0, 0, 0, 12'h000, 32'h0);
    applyStimulus(1, 0, 12'h030, 32'h0, 1, 1, 12'h030, 32'h9);
    applyStimulus(1, 1, 12'h040, 32'hAB, 1, 0, 12'h040, 32'h0);
    applyStimulus(1, 0, 12'h030, 32'h0, 1, 0, 12'h040, 32'h0);

    $display("[TB] reset during second cycle");
    resetInSecond(12'h050, 32'h1234);
    applyStimulus(1, 0, 12'h050, 32'h0, 0, 0, 12'h000, 32'h0);

    $display("[TB] saturation");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, 12'h060, 32'h0, 1, 1, 12'h060, 32'h100 + i);
    checkOutput("small_saturated", {30'b0, sm_conflict_count}, 32'd3);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++)
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 12'h100 + 12'($urandom_range(0, 5)),
                    $urandom, $urandom_range(0, 7) != 0, 1'($urandom),
                    12'h100 + 12'($urandom_range(0, 5)), $urandom);

    req_a = 0; req_b = 0;
    repeat (3) @(posedge clock);
    #3;
    checkOutput("queue_a_drained", exp_a_q.size(), 32'd0);
    checkOutput("queue_b_drained", exp_b_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lane_arbiter.md
Name: dmem_lane_arbiter

Overview:
- Sits between the two execute/memory lanes of the 2-wide pipeline and the dual-port dmem2 (ports a and b).
- Lane a is always the older instruction and lane b the younger.
- Passes independent accesses straight through and merges same-address write pairs.
- Serializes same-address read/write pairs over two cycles with a pipeline stall, so results always match program order.
- Registers read data, and counts conflicts for performance analysis.

Parameters:
ADDR_W, 12, dmem word-address width
DATA_W, 32, data width
CNT_W, 16, width of conflict counter

Ports:
clock  in  1  master clock; rising edge; dmem runs on ~clock
reset  in  1  synchronous, active-high
req_a  in  1  lane a memory op valid
we_a  in  1  lane a op is store (1) / load (0)
addr_a  in  ADDR_W  lane a word address
wdata_a  in  DATA_W  lane a store data
req_b  in  1  lane b memory op valid
we_b  in  1  lane b store/load
addr_b  in  ADDR_W  lane b word address
wdata_b  in  DATA_W  lane b store data
address_dmem_a  out  ADDR_W  dmem port a address
address_dmem_b  out  ADDR_W  dmem port b address
data_a  out  DATA_W  dmem port a write data
data_b  out  DATA_W  dmem port b write data
wren_a  out  1  dmem port a write enable
wren_b  out  1  dmem port b write enable
q_dmem_a  in  DATA_W  dmem port a read data; valid before next rising edge
q_dmem_b  in  DATA_W  dmem port b read data
rdata_a  out  DATA_W  registered load result, lane a
rdata_b  out  DATA_W  registered load result, lane b
rvalid_a  out  1  rdata_a valid (one-cycle pulse)
rvalid_b  out  1  rdata_b valid (one-cycle pulse)
stall  out  1  hold both lanes' inputs stable next cycle
conflict_count  out  CNT_W  saturating count of serialized pairs

Behaviour:
- Reset values:
  - State is IDLE.
  - rdata_a and rdata_b are 0.
  - rvalid_a, rvalid_b and conflict_count are 0.
  - stall is 0.
  - wren_a and wren_b are forced 0 combinationally in any cycle where reset=1.
- Conflict definition: same = req_a & req_b & (addr_a == addr_b).
- Classification, evaluated in IDLE:
  - PASS: !same, or both loads. Lane a drives port a and lane b drives port b in the same cycle; stall=0.
  - MERGE: same & we_a & we_b. Only lane b's store is issued (port b, wren_b=1) and wren_a=0, because the younger store wins. No stall; not counted.
  - SERIAL: same and exactly one op is a store.
    - Cycle 1: only lane a is issued on port a, wren_b=0, stall=1; go to SECOND.
    - Cycle 2 (SECOND): only lane b is issued on port b, wren_a=0, stall=0; return to IDLE.
    - conflict_count increments by 1 on entry to SECOND and saturates at all-ones.
- SECOND ignores new classification. Inputs are required to be unchanged from cycle 1 (guaranteed by stall).
- Port outputs when a lane is not issued: address = that lane's addr, data = that lane's wdata, wren = 0.
- Read latency: a load issued in cycle N has q_dmem captured into rdata_x at the rising edge ending cycle N, and rvalid_x=1 during cycle N+1 only.
- rdata_x holds its last value when rvalid_x=0.
- req=0 on a lane: no write and no rvalid for that lane.
- Reset while in SECOND: the pending lane b op is dropped (no write), state goes to IDLE, and the counter clears.
- Address compare is on the full ADDR_W bits; there is no wrap or alias handling.

Optional Feature:
- Macro: DMEM_ARB_FWD_EN.
- When defined, the SERIAL sub-case "a=store, b=load, same address" is not serialized:
  - a's store issues on port a and b's read is suppressed.
  - rdata_b is loaded with wdata_a, and rvalid_b=1 the next cycle.
  - stall=0 and the counter does not increment.
- "a=load, b=store" still serializes.
- When undefined, both sub-cases serialize as above.

Test Plan:
- PASS case: req_a=1, we_a=0, addr_a=0x010, with q_dmem_a=0xDEADBEEF; req_b=1, we_b=1, addr_b=0x011, wdata_b=0x5 -> same cycle wren_b=1, address_dmem_b=0x011, stall=0; next cycle rvalid_a=1, rdata_a=0xDEADBEEF.
- MERGE case: both stores to 0x020, wdata_a=0x1, wdata_b=0x2 -> wren_a=0, wren_b=1, data_b=0x2, stall=0, conflict_count stays 0.
- SERIAL case: a load at 0x030 (memory 0x7), b store 0x9 at 0x030 -> cycle 1 stall=1, wren_b=0; cycle 2 rvalid_a=1, rdata_a=0x7, wren_b=1, data_b=0x9, stall=0; conflict_count=1.
- FWD case: a store 0xAB at 0x040, b load at 0x040 -> without DMEM_ARB_FWD_EN: 2-cycle serialize, rdata_b=0xAB; with DMEM_ARB_FWD_EN: stall=0, rdata_b=0xAB next cycle, counter unchanged.
- Reset mid-op: assert reset during SECOND -> wren_b=0 that cycle, state IDLE, conflict_count=0, rvalid_b=0 next cycle.
- Saturation: CNT_W=2, run 5 SERIAL pairs -> conflict_count=3 and holds.
